rams_dp_pipelined: RTL and testbench
====================================

// Module: rams_dp_pipelined
// PURPOSE
//  Parametrised dual-port RAM: one read/write port A (byte-enable writes) and one read-only port B.
//  Both read ports are synchronous, with an optional second output register stage for timing closure.
//  Per-port read enables produce valid strobes aligned to the read data.
//  A collision flag reports port-B reads of an address port A writes in the same cycle.
//  Drop-in for register-file and buffer storage in larger datapaths; maps to block RAM.
// PARAMETERS
//  DATA_WIDTH  16  word width; must be a multiple of BYTE_WIDTH
//  BYTE_WIDTH  8   bits per write-enable lane
//  ADDR_WIDTH  6   address width; DEPTH = 2**ADDR_WIDTH words
//  WRITE_MODE  0   port A read/write behaviour: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
//  OUT_REG     0   0 = 1-cycle read latency, 1 = 2-cycle latency (extra output register)
// PORTS
//  clk        in   1              rising-edge clock, sole clock domain
//  rst        in   1              synchronous active-high reset
//  en_a       in   1              port A enable; gates both read and write on A
//  we         in   DATA_WIDTH/BYTE_WIDTH  per-lane write enable, port A
//  a          in   ADDR_WIDTH     port A address
//  di         in   DATA_WIDTH     port A write data
//  en_b       in   1              port B read enable
//  dpra       in   ADDR_WIDTH     port B read address
//  spo        out  DATA_WIDTH     port A read data
//  spo_valid  out  1              spo holds a result for an accepted en_a cycle
//  dpo        out  DATA_WIDTH     port B read data
//  dpo_valid  out  1              dpo holds a result for an accepted en_b cycle
//  collision  out  1              the dpo result came from an address written that cycle; aligned to dpo_valid
// BEHAVIOUR
//  - Reset: spo, dpo, all pipeline data regs = 0; spo_valid, dpo_valid, collision = 0.
//    RAM contents are not cleared. Writes are suppressed while rst = 1.
//  - Reset mid-operation flushes all in-flight reads: valids are low the cycle after rst deasserts.
//    The first new result appears per the normal latency.
//  - Write: en_a & we[i] & !rst at edge -> ram[a][i*BYTE_WIDTH +: BYTE_WIDTH] <= di lane i.
//    Lanes with we[i] = 0 are unchanged.
//  - Port A read (en_a = 1), by WRITE_MODE:
//    READ_FIRST: spo = old word.
//    WRITE_FIRST: spo = merged word (new lanes where we[i], old elsewhere).
//    NO_CHANGE: spo holds its previous value when any we bit is set; spo_valid still pulses.
//  - Port B read (en_b = 1): dpo = ram[dpra] before any same-cycle port-A write.
//    Port B is always read-first.
//  - Collision: en_b & en_a & |we & (dpra == a) -> collision = 1 alongside that dpo_valid.
//  - Latency: OUT_REG = 0 -> data and valid one cycle after the enable edge.
//    OUT_REG = 1 -> two cycles.
//    Both stages advance every cycle: no backpressure, fully pipelined, one read per port per cycle.
//  - en low: the stage-1 data register holds; valid = 0 in the corresponding output cycle.
//    Output data holds its last value.
//  - Addresses wrap naturally; there are no out-of-range addresses.
//  - Simultaneous same-address access on both ports is legal, with the behaviour defined above.
// STRUCTURE
//  - Shared header rams_defs.vh: WRITE_MODE codes
//    (RAMS_READ_FIRST = 0, RAMS_WRITE_FIRST = 1, RAMS_NO_CHANGE = 2) and the lane-count macro.
//  - Sub-module rams_out_stage: optional register stage (data, valid, collision) with sync reset.
//    It is instantiated per port; the generate uses OUT_REG to choose register or pass-through.
//  - The memory array and stage-1 regs stay in the top so synthesis infers block RAM.
//    Reset touches only the valid and output registers.
// TESTING
//  1. OUT_REG = 0, READ_FIRST: write 0xA5A5 @5, then en_a read @5 with we = 2'b01, di = 0x1234.
//     Required: spo = 0xA5A5 with spo_valid; a following read gives 0xA534.
//  2. WRITE_FIRST, same stimulus.
//     Required: spo = 0xA534 the cycle after the write. NO_CHANGE: spo holds its prior value, spo_valid = 1.
//  3. Collision: en_b @dpra = 9 while writing 0xBEEF @9 over 0x0000.
//     Required: dpo = 0x0000, collision = 1, dpo_valid = 1. The next port-B read @9 gives 0xBEEF, collision = 0.
//  4. OUT_REG = 1: back-to-back en_b reads @0..@7 of pre-written data k*0x11.
//     Required: dpo_valid high for 8 consecutive cycles starting 2 cycles after the first enable, data in order.
//  5. Reset mid-stream: assert rst for 1 cycle during test 4 with we active.
//     Required: valids drop with no stale result; the write in the reset cycle is not committed; RAM otherwise intact.
//  6. Random en/we/address on both ports for 10k cycles against a behavioural model.
//     Required: zero data, valid or collision mismatches.

Source files
------------

// File: rtl/rams_dp_pipelined_pkg.sv
// Shared constants for the pipelined dual-port RAM: port-A write-mode codes
// and the byte-lane count helper.
package rams_dp_pipelined_pkg;

   localparam int RAMS_READ_FIRST  = 0;
   localparam int RAMS_WRITE_FIRST = 1;
   localparam int RAMS_NO_CHANGE   = 2;

   function automatic int lane_count(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/rams_dp_pipelined_if.sv
// Bus bundle for rams_dp_pipelined: port A read/write, port B read-only, and
// the aligned read results.
interface rams_dp_pipelined_if
   import rams_dp_pipelined_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);
   localparam int LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);

   // There is no ready: an enable sampled high on a clock edge is always
   // accepted, and its *_valid pulses for exactly one cycle at the read latency.
   logic                  en_a;
   logic [LANES-1:0]      we;
   logic [ADDR_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] di;
   logic                  en_b;
   logic [ADDR_WIDTH-1:0] dpra;
   logic [DATA_WIDTH-1:0] spo;
   logic                  spo_valid;
   logic [DATA_WIDTH-1:0] dpo;
   logic                  dpo_valid;
   logic                  collision;

   modport master (
      output en_a, we, a, di, en_b, dpra,
      input  spo, spo_valid, dpo, dpo_valid, collision
   );

   modport slave (
      input  en_a, we, a, di, en_b, dpra,
      output spo, spo_valid, dpo, dpo_valid, collision
   );

endinterface

// File: rtl/rams_dp_pipelined_out_stage.sv
// Optional second read register: data and valid advance every cycle, both
// cleared by synchronous reset.
module rams_out_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] prev_data,
   input  logic             prev_valid,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         data  <= prev_data;
         valid <= prev_valid;
      end
   end

endmodule

// File: rtl/rams_dp_pipelined.sv
// Dual-port RAM with byte-enable port A, read-only port B, valid strobes,
// same-address collision flag and an optional extra output register.
module rams_dp_pipelined
   import rams_dp_pipelined_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int WRITE_MODE = RAMS_READ_FIRST,
   parameter int OUT_REG    = 0
) (
   input  logic                clk,
   input  logic                rst,
   rams_dp_pipelined_if.slave  bus
);

   localparam int LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged_word;
   logic                  write_any;

   logic [DATA_WIDTH-1:0] spo_s1;
   logic                  spo_v1;
   logic [DATA_WIDTH-1:0] dpo_s1;
   logic                  dpo_v1;
   logic                  coll_s1;

   logic [DATA_WIDTH-1:0] spo_out;
   logic                  spo_v_out;
   logic [DATA_WIDTH:0]   dpo_pack_out;
   logic                  dpo_v_out;

   always_comb begin
      old_word    = ram[bus.a];
      merged_word = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (bus.we[i]) begin
            merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.di[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign write_any = bus.en_a & (|bus.we);

   // Memory array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (!rst && bus.en_a) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.we[i]) begin
               ram[bus.a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.di[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spo_s1  <= '0;
         spo_v1  <= 1'b0;
         dpo_s1  <= '0;
         dpo_v1  <= 1'b0;
         coll_s1 <= 1'b0;
      end else begin
         spo_v1  <= bus.en_a;
         dpo_v1  <= bus.en_b;
         coll_s1 <= bus.en_b & write_any & (bus.dpra == bus.a);
         if (bus.en_b) begin
            dpo_s1 <= ram[bus.dpra];
         end
         if (bus.en_a) begin
            case (WRITE_MODE)
               RAMS_WRITE_FIRST: spo_s1 <= merged_word;
               RAMS_NO_CHANGE: begin
                  if (!write_any) begin
                     spo_s1 <= old_word;
                  end
               end
               default: spo_s1 <= old_word;
            endcase
         end
      end
   end

   // Collision rides alongside port-B data so it stays aligned to dpo_valid.
   generate
      if (OUT_REG != 0) begin : g_out_reg
         rams_out_stage #(.WIDTH(DATA_WIDTH)) u_stage_a (
            .clk        (clk),
            .rst        (rst),
            .prev_data  (spo_s1),
            .prev_valid (spo_v1),
            .data       (spo_out),
            .valid      (spo_v_out)
         );
         rams_out_stage #(.WIDTH(DATA_WIDTH + 1)) u_stage_b (
            .clk        (clk),
            .rst        (rst),
            .prev_data  ({coll_s1, dpo_s1}),
            .prev_valid (dpo_v1),
            .data       (dpo_pack_out),
            .valid      (dpo_v_out)
         );
      end else begin : g_out_pass
         assign spo_out      = spo_s1;
         assign spo_v_out    = spo_v1;
         assign dpo_pack_out = {coll_s1, dpo_s1};
         assign dpo_v_out    = dpo_v1;
      end
   endgenerate

   assign bus.spo       = spo_out;
   assign bus.spo_valid = spo_v_out;
   assign bus.dpo       = dpo_pack_out[DATA_WIDTH-1:0];
   assign bus.collision = dpo_pack_out[DATA_WIDTH];
   assign bus.dpo_valid = dpo_v_out;

endmodule

// File: tb/tb_rams_dp_pipelined.sv
// Bench for rams_dp_pipelined: four instances (READ_FIRST, WRITE_FIRST,
// NO_CHANGE at latency 1, READ_FIRST at latency 2) share one stimulus stream.
module tb_rams_dp_pipelined;

   typedef struct packed {
      logic [15:0] spo;
      logic        spo_v;
      logic [15:0] dpo;
      logic        dpo_v;
      logic        coll;
   } res_t;

   typedef struct packed {
      logic        en_a;
      logic [1:0]  we;
      logic [5:0]  a;
      logic [15:0] di;
      logic        en_b;
      logic [5:0]  dpra;
      logic [15:0] exp_rf;
      logic [15:0] exp_wf;
      logic [15:0] exp_nc;
      logic        exp_spo_v;
      logic [15:0] exp_dpo;
      logic        exp_dpo_v;
      logic        exp_coll;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        en_a = 1'b0;
   logic [1:0]  we   = '0;
   logic [5:0]  a    = '0;
   logic [15:0] di   = '0;
   logic        en_b = 1'b0;
   logic [5:0]  dpra = '0;

   rams_dp_pipelined_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if_rf ();
   rams_dp_pipelined_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if_wf ();
   rams_dp_pipelined_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if_nc ();
   rams_dp_pipelined_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if_p ();

   assign if_rf.en_a = en_a;  assign if_rf.we = we;  assign if_rf.a = a;
   assign if_rf.di = di;      assign if_rf.en_b = en_b;  assign if_rf.dpra = dpra;
   assign if_wf.en_a = en_a;  assign if_wf.we = we;  assign if_wf.a = a;
   assign if_wf.di = di;      assign if_wf.en_b = en_b;  assign if_wf.dpra = dpra;
   assign if_nc.en_a = en_a;  assign if_nc.we = we;  assign if_nc.a = a;
   assign if_nc.di = di;      assign if_nc.en_b = en_b;  assign if_nc.dpra = dpra;
   assign if_p.en_a = en_a;   assign if_p.we = we;   assign if_p.a = a;
   assign if_p.di = di;       assign if_p.en_b = en_b;   assign if_p.dpra = dpra;

   rams_dp_pipelined #(.WRITE_MODE(0), .OUT_REG(0)) u_rf (.clk(clk), .rst(rst), .bus(if_rf.slave));
   rams_dp_pipelined #(.WRITE_MODE(1), .OUT_REG(0)) u_wf (.clk(clk), .rst(rst), .bus(if_wf.slave));
   rams_dp_pipelined #(.WRITE_MODE(2), .OUT_REG(0)) u_nc (.clk(clk), .rst(rst), .bus(if_nc.slave));
   rams_dp_pipelined #(.WRITE_MODE(0), .OUT_REG(1)) u_p  (.clk(clk), .rst(rst), .bus(if_p.slave));

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] mdl_mem [64];
   logic [15:0] hold_spo [3];
   logic [15:0] hold_dpo;
   res_t        exp0 [3];
   res_t        exp_p;
   logic [34:0] exp_q [$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input string tag, input logic [15:0] spo, input logic spo_v,
                           input logic [15:0] dpo, input logic dpo_v, input logic coll,
                           input res_t e);
      chk({tag, "_spo"}, spo, e.spo);
      chk({tag, "_spo_valid"}, {15'd0, spo_v}, {15'd0, e.spo_v});
      chk({tag, "_dpo"}, dpo, e.dpo);
      chk({tag, "_dpo_valid"}, {15'd0, dpo_v}, {15'd0, e.dpo_v});
      chk({tag, "_collision"}, {15'd0, coll}, {15'd0, e.coll});
   endtask

   // Model the edge from the inputs currently applied, clock once, then compare.
   task automatic step(input bit check);
      logic [15:0] old_w, mrg_w;
      logic        wr;
      old_w = mdl_mem[a];
      mrg_w = old_w;
      for (int l = 0; l < 2; l++) begin
         if (we[l]) mrg_w[l*8 +: 8] = di[l*8 +: 8];
      end
      wr = en_a && (we != 2'b00);
      for (int m = 0; m < 3; m++) begin
         if (rst) begin
            hold_spo[m] = '0;
         end else if (en_a) begin
            if (m == 1) hold_spo[m] = mrg_w;
            else if (m == 2) hold_spo[m] = wr ? hold_spo[m] : old_w;
            else hold_spo[m] = old_w;
         end
      end
      if (rst) hold_dpo = '0;
      else if (en_b) hold_dpo = mdl_mem[dpra];
      for (int m = 0; m < 3; m++) begin
         exp0[m].spo   = hold_spo[m];
         exp0[m].spo_v = !rst && en_a;
         exp0[m].dpo   = hold_dpo;
         exp0[m].dpo_v = !rst && en_b;
         exp0[m].coll  = !rst && en_b && wr && (dpra == a);
      end
      if (!rst && en_a) begin
         for (int l = 0; l < 2; l++) begin
            if (we[l]) mdl_mem[a][l*8 +: 8] = di[l*8 +: 8];
         end
      end
      if (rst) begin
         exp_q.delete();
         exp_p = '0;
         exp_q.push_back('0);
      end else begin
         exp_p = res_t'(exp_q.pop_front());
         exp_q.push_back(exp0[0]);
      end
      @(posedge clk);
      #1;
      if (check) begin
         cmp_inst("rf", if_rf.spo, if_rf.spo_valid, if_rf.dpo, if_rf.dpo_valid, if_rf.collision, exp0[0]);
         cmp_inst("wf", if_wf.spo, if_wf.spo_valid, if_wf.dpo, if_wf.dpo_valid, if_wf.collision, exp0[1]);
         cmp_inst("nc", if_nc.spo, if_nc.spo_valid, if_nc.dpo, if_nc.dpo_valid, if_nc.collision, exp0[2]);
         cmp_inst("p",  if_p.spo,  if_p.spo_valid,  if_p.dpo,  if_p.dpo_valid,  if_p.collision,  exp_p);
      end
   endtask

   // ---------------- driver / test sequence ----------------
   vec_t vecs [12];

   initial begin
      bit exp_v;

      for (int k = 0; k < 64; k++) mdl_mem[k] = '0;
      for (int m = 0; m < 3; m++) hold_spo[m] = '0;
      hold_dpo = '0;
      exp_q.push_back('0);

      //              en_a we     a      di        en_b dpra   rf        wf        nc        sv    dpo       dv    coll
      vecs[0]  = '{1'b1, 2'b11, 6'd5,  16'hA5A5, 1'b0, 6'd0,  16'h0055, 16'hA5A5, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 2'b01, 6'd5,  16'h1234, 1'b0, 6'd0,  16'hA5A5, 16'hA534, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 2'b00, 6'd5,  16'h0000, 1'b0, 6'd0,  16'hA534, 16'hA534, 16'hA534, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 2'b11, 6'd9,  16'h0000, 1'b0, 6'd0,  16'h0099, 16'h0000, 16'hA534, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 2'b11, 6'd9,  16'hBEEF, 1'b1, 6'd9,  16'h0000, 16'hBEEF, 16'hA534, 1'b1, 16'h0000, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 2'b00, 6'd9,  16'h0000, 1'b1, 6'd9,  16'h0000, 16'hBEEF, 16'hA534, 1'b0, 16'hBEEF, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 2'b10, 6'd9,  16'h1200, 1'b1, 6'd8,  16'hBEEF, 16'h12EF, 16'hA534, 1'b1, 16'h0088, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 2'b11, 6'd9,  16'hFFFF, 1'b1, 6'd9,  16'hBEEF, 16'h12EF, 16'hA534, 1'b0, 16'h12EF, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 2'b00, 6'd9,  16'h0000, 1'b0, 6'd9,  16'h12EF, 16'h12EF, 16'h12EF, 1'b1, 16'h12EF, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 2'b00, 6'd3,  16'h0000, 1'b1, 6'd3,  16'h0033, 16'h0033, 16'h0033, 1'b1, 16'h0033, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 2'b11, 6'd63, 16'hCAFE, 1'b1, 6'd63, 16'h042F, 16'hCAFE, 16'h0033, 1'b1, 16'h042F, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 2'b00, 6'd63, 16'h0000, 1'b1, 6'd63, 16'h042F, 16'hCAFE, 16'h0033, 1'b0, 16'hCAFE, 1'b1, 1'b0};

      // reset state
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1);
      cmp_inst("rst_rf", if_rf.spo, if_rf.spo_valid, if_rf.dpo, if_rf.dpo_valid, if_rf.collision, '0);
      cmp_inst("rst_wf", if_wf.spo, if_wf.spo_valid, if_wf.dpo, if_wf.dpo_valid, if_wf.collision, '0);
      cmp_inst("rst_nc", if_nc.spo, if_nc.spo_valid, if_nc.dpo, if_nc.dpo_valid, if_nc.collision, '0);
      cmp_inst("rst_p",  if_p.spo,  if_p.spo_valid,  if_p.dpo,  if_p.dpo_valid,  if_p.collision,  '0);
      rst = 1'b0;

      // prefill mem[k] = k*0x11; RAM power-up contents are unknown so reads are unchecked
      for (int k = 0; k < 64; k++) begin
         en_a = 1'b1; we = 2'b11; a = 6'(k); di = 16'(k * 17);
         step(1'b0);
      end
      en_a = 1'b1; we = 2'b00; a = '0; en_b = 1'b1; dpra = '0;
      step(1'b0);
      step(1'b0);

      // directed vectors: write modes, byte lanes, collision, wrap address
      for (int i = 0; i < 12; i++) begin
         en_a = vecs[i].en_a; we = vecs[i].we; a = vecs[i].a; di = vecs[i].di;
         en_b = vecs[i].en_b; dpra = vecs[i].dpra;
         step(1'b1);
         chk($sformatf("vec%0d_rf_spo", i), if_rf.spo, vecs[i].exp_rf);
         chk($sformatf("vec%0d_wf_spo", i), if_wf.spo, vecs[i].exp_wf);
         chk($sformatf("vec%0d_nc_spo", i), if_nc.spo, vecs[i].exp_nc);
         chk($sformatf("vec%0d_spo_valid", i), {15'd0, if_nc.spo_valid}, {15'd0, vecs[i].exp_spo_v});
         chk($sformatf("vec%0d_dpo", i), if_rf.dpo, vecs[i].exp_dpo);
         chk($sformatf("vec%0d_dpo_valid", i), {15'd0, if_rf.dpo_valid}, {15'd0, vecs[i].exp_dpo_v});
         chk($sformatf("vec%0d_collision", i), {15'd0, if_rf.collision}, {15'd0, vecs[i].exp_coll});
      end

      // restore mem[5] for the streaming read
      en_a = 1'b1; we = 2'b11; a = 6'd5; di = 16'h0055; en_b = 1'b0;
      step(1'b1);
      en_a = 1'b0; we = 2'b00;

      // two-cycle latency: back-to-back port-B reads @0..7
      for (int j = 0; j < 11; j++) begin
         en_b = (j < 8); dpra = 6'(j);
         step(1'b1);
         exp_v = (j >= 1 && j <= 8);
         chk($sformatf("stream%0d_valid", j), {15'd0, if_p.dpo_valid}, {15'd0, exp_v});
         if (exp_v) chk($sformatf("stream%0d_dpo", j), if_p.dpo, 16'((j - 1) * 17));
      end

      // same stream with a one-cycle reset carrying a write to @20
      for (int j = 0; j < 11; j++) begin
         en_b = (j < 8); dpra = 6'(j);
         rst  = (j == 3);
         en_a = (j == 3); we = 2'b11; a = 6'd20; di = 16'hDEAD;
         step(1'b1);
         exp_v = (j == 1 || j == 2 || (j >= 5 && j <= 8));
         chk($sformatf("rststream%0d_valid", j), {15'd0, if_p.dpo_valid}, {15'd0, exp_v});
         if (exp_v) chk($sformatf("rststream%0d_dpo", j), if_p.dpo, 16'((j - 1) * 17));
      end
      rst = 1'b0; en_a = 1'b0; we = 2'b00;
      en_b = 1'b1; dpra = 6'd20;
      step(1'b1);
      chk("rst_write_dropped_rf", if_rf.dpo, 16'h0154);
      en_b = 1'b0;
      step(1'b1);
      chk("rst_write_dropped_p", if_p.dpo, 16'h0154);

      // random traffic on a narrow address window to force collisions
      for (int i = 0; i < 10000; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         en_a = 1'($urandom_range(0, 1));
         we   = 2'($urandom_range(0, 3));
         a    = 6'($urandom_range(0, 15));
         di   = 16'($urandom);
         en_b = 1'($urandom_range(0, 1));
         dpra = 6'($urandom_range(0, 15));
         step(1'b1);
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
